// File: rtl/param_adder.sv
// param_adder: N-bit grouped carry-lookahead adder with registered sum, carry, overflow and valid
module param_adder #(
    parameter int N     = 5,
    parameter int GROUP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         out_valid
);
    localparam int NG = (N + GROUP - 1) / GROUP;
    logic [N-1:0]  g, p, s_d, s_q;
    logic [N:0]    c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          acc_g, acc_p, cout_q, ovf_q, valid_q;
    // bit g/p, group G/P, second-level group carries, then in-group lookahead carries
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        c     = '0;
        acc_g = 1'b0;
        acc_p = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc_g = (i % GROUP == 0) ? 1'b0 : acc_g;
            acc_p = (i % GROUP == 0) ? 1'b1 : acc_p;
            acc_g = g[i] | (p[i] & acc_g);
            acc_p = acc_p & p[i];
            gg[i / GROUP] = acc_g;
            gp[i / GROUP] = acc_p;
        end
        gc[0] = cin;
        acc_g = 1'b0;
        acc_p = 1'b1;
        for (int k = 0; k < NG; k++) begin
            acc_g     = gg[k] | (gp[k] & acc_g);
            acc_p     = acc_p & gp[k];
            gc[k + 1] = acc_g | (acc_p & cin);
        end
        acc_g = 1'b0;
        acc_p = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc_g = (i % GROUP == 0) ? 1'b0 : acc_g;
            acc_p = (i % GROUP == 0) ? 1'b1 : acc_p;
            c[i]  = acc_g | (acc_p & gc[i / GROUP]);
            acc_g = g[i] | (p[i] & acc_g);
            acc_p = acc_p & p[i];
        end
        c[N] = gc[NG];
        s_d  = p ^ c[N-1:0];
    end
    // output register: reset wins, results load only on in_valid, valid is in_valid delayed
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= c[N];
                ovf_q  <= c[N-1] ^ c[N];
            end
        end
    end
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_param_adder.sv
// tb_param_adder: scoreboard bench for param_adder, N=5 over several group sizes plus N=16 random
module tb_param_adder;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;
    localparam int GR[4] = '{1, 2, 4, 5};
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst5 = 1'b1, v5 = 1'b0, cin5 = 1'b0;
    logic [4:0] a5 = '0, b5 = '0;
    logic [4:0] s5 [4];
    logic       co5 [4], ov5 [4], vo5 [4];
    logic        rst16 = 1'b1, v16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        co16, ov16, vo16;
    exp_t q5[$], q16[$];
    int checks = 0, errors = 0;
    for (genvar i = 0; i < 4; i++) begin : g5
        param_adder #(.N(5), .GROUP(GR[i])) dut (
            .clk(clk), .rst(rst5), .in_valid(v5), .a(a5), .b(b5), .cin(cin5),
            .s(s5[i]), .cout(co5[i]), .ovf(ov5[i]), .out_valid(vo5[i])
        );
    end
    param_adder #(.N(16), .GROUP(4)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(v16), .a(a16), .b(b16), .cin(cin16),
        .s(s16), .cout(co16), .ovf(ov16), .out_valid(vo16)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic exp_t model(input int n, input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] mask, sum;
        exp_t e;
        mask = (17'd1 << n) - 17'd1;
        sum  = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, ci};
        e.s  = sum[15:0] & mask[15:0];
        e.c  = sum[n];
        e.o  = (a[n-1] == b[n-1]) && (e.s[n-1] != a[n-1]);
        return e;
    endfunction
    function automatic exp_t mk(input logic [4:0] s, input logic c, input logic o);
        exp_t e;
        e.s = {11'd0, s};
        e.c = c;
        e.o = o;
        return e;
    endfunction
    task automatic drv5(input logic v, input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic ci, input exp_t e);
        @(negedge clk);
        rst5 = r; v5 = v; a5 = a; b5 = b; cin5 = ci;
        if (v && !r) q5.push_back(e);
    endtask
    task automatic drv16(input logic v, input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
        @(negedge clk);
        rst16 = r; v16 = v; a16 = a; b16 = b; cin16 = ci;
        if (v && !r) q16.push_back(model(16, a, b, ci));
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (vo5[0] | vo5[1] | vo5[2] | vo5[3]) begin
            if (q5.size() == 0) chk("spurious_valid5", 1, 0);
            else begin
                e = q5.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk("valid5", {31'd0, vo5[k]}, 1);
                    chk("result5", {25'd0, co5[k], ov5[k], s5[k]}, {25'd0, e.c, e.o, e.s[4:0]});
                end
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (vo16) begin
            if (q16.size() == 0) chk("spurious_valid16", 1, 0);
            else begin
                e = q16.pop_front();
                chk("result16", {14'd0, co16, ov16, s16}, {14'd0, e.c, e.o, e.s});
            end
        end
    end
    initial begin
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    drv5(1, 1, 5'b11111, 5'b00001, 1, mk(0, 0, 0));
                    @(posedge clk); #1;
                    for (int k = 0; k < 4; k++)
                        chk("reset5", {24'd0, vo5[k], co5[k], ov5[k], s5[k]}, 0);
                end
                drv5(1, 0, 5'b10101, 5'b01010, 0, mk(5'b11111, 0, 0));
                drv5(1, 0, 5'b11111, 5'b00001, 1, mk(5'b00001, 1, 0));
                drv5(1, 0, 5'b00100, 5'b00111, 0, mk(5'b01011, 0, 0));
                drv5(1, 0, 5'b01111, 5'b00001, 0, mk(5'b10000, 0, 1));
                drv5(1, 0, 5'b10000, 5'b10000, 0, mk(5'b00000, 1, 1));
                drv5(1, 0, 5'b11111, 5'b00000, 1, mk(5'b00000, 1, 0));
                drv5(1, 0, 5'b11111, 5'b11111, 1, mk(5'b11111, 1, 0));
                drv5(1, 0, 5'b00011, 5'b00100, 1, mk(5'b01000, 0, 0));
                for (int h = 0; h < 3; h++) begin
                    drv5(0, 0, 5'(h * 7 + 3), 5'(h * 5 + 9), 1, mk(0, 0, 0));
                    @(posedge clk); #1;
                    for (int k = 0; k < 4; k++)
                        chk("hold5", {24'd0, vo5[k], co5[k], ov5[k], s5[k]}, {24'd0, 3'b000, 5'b01000});
                end
                for (int ci = 0; ci < 2; ci++)
                    for (int x = 0; x < 32; x++)
                        for (int y = 0; y < 32; y++)
                            drv5(1, 0, 5'(x), 5'(y), 1'(ci), model(5, 16'(x), 16'(y), 1'(ci)));
                drv5(0, 0, 0, 0, 0, mk(0, 0, 0));
                drv5(0, 0, 0, 0, 0, mk(0, 0, 0));
                drv5(0, 0, 0, 0, 0, mk(0, 0, 0));
                chk("drain5", q5.size(), 0);
            end
            begin
                drv16(0, 1, 0, 0, 0);
                drv16(0, 1, 0, 0, 0);
                for (int n = 0; n < 10000; n++) begin
                    drv16(1, (n >= 5000 && n < 5003), 16'($urandom), 16'($urandom), 1'($urandom));
                    if (n == 5002) begin
                        @(posedge clk); #1;
                        chk("midrst16", {13'd0, vo16, co16, ov16, s16}, 0);
                    end
                end
                drv16(0, 0, 0, 0, 0);
                drv16(0, 0, 0, 0, 0);
                drv16(0, 0, 0, 0, 0);
                chk("drain16", q16.size(), 0);
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
